dual_wheel_encoder_emulator: RTL and testbench
==============================================

Name: dual_wheel_encoder_emulator

Overview:
Generates two-wheel quadrature encoder signals (A/B per wheel) from a motion command. It is the transmitter counterpart of the dual-wheel encoder decoder. It is used as a hardware-in-the-loop stimulus source and for bench self-test of the odometry path. Each command produces a programmed number of quadrature edges per wheel, in a programmed direction, at a programmed edge period; completion is signalled by a handshake.

Parameters:
COUNT_W, 16, width of edge-count command and progress counters
PERIOD_W, 16, width of edge-period command (clock cycles per edge)
MIN_PERIOD, 2, lower clamp applied to any commanded period

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  command strobe; accepted only while ready=1
abort  in  1  stops a running command
dir_left  in  1  0=CW, 1=CCW, left wheel
dir_right  in  1  0=CW, 1=CCW, right wheel
edges_left  in  COUNT_W  quadrature edges to emit, left wheel
edges_right  in  COUNT_W  quadrature edges to emit, right wheel
period_left  in  PERIOD_W  clocks between left edges
period_right  in  PERIOD_W  clocks between right edges
A_left, B_left  out  1  left quadrature outputs (registered)
A_right, B_right  out  1  right quadrature outputs (registered)
ready  out  1  idle; a command may be issued
busy  out  1  command in progress
done  out  1  one-cycle completion pulse
edges_done_left  out  COUNT_W  edges emitted in the current or last command
edges_done_right  out  COUNT_W  edges emitted in the current or last command

Behaviour:
- Reset (async, any state): all A/B=0; ready=1; busy=0; done=0; edges_done_*=0; FSM=IDLE.
- FSM states are IDLE, RUN, DONE. ready=1 only in IDLE; busy=1 only in RUN; done=1 only in DONE.
- IDLE→RUN on a clock edge with start=1 and abort=0. At that edge:
  - Latch dir_*, edges_* and period_*. A latched period below MIN_PERIOD becomes MIN_PERIOD.
  - Clear the per-wheel cycle counters and edges_done_*.
- start=1 while not in IDLE is ignored. start and abort together in IDLE: ignored.
- In RUN, each wheel with remaining>0 runs independently:
  - The cycle counter increments every clock.
  - When counter==period-1, on that edge: advance phase by one step, remaining--, edges_done++, counter←0.
  - The first edge is visible `period` cycles after the accepting edge T; edge k is visible at T+k*period.
- A wheel with edges=0 emits nothing and holds its outputs.
- Phase sequence (A,B):
  - CW: 00→10→11→01→00.
  - CCW: 00→01→11→10→00.
  - Exactly one bit changes per edge. The phase persists across commands (it is not re-zeroed at start).
- RUN→DONE on the edge after both remaining counts reach 0. done is high for exactly that one cycle, then the FSM returns to IDLE. A command with both edges=0 gives RUN for 1 cycle, then DONE.
- abort=1 in RUN: the FSM goes to IDLE at the next edge. No done pulse. A/B hold their current phase. edges_done_* hold their partial counts. abort is ignored in IDLE and DONE.
- Counters are unsigned, with no wrap. edges up to 2^COUNT_W-1 are honoured exactly.
- Reset mid-RUN: outputs go to 00 immediately (asynchronously).

Optional Feature:
Macro ENCODER_BOUNCE_INJECT_EN.
- Defined:
  - Adds input port bounce_en (1 bit).
  - When bounce_en=1, on every edge that raises A_x, the A output is forced low for the single cycle after the edge, then returns high.
  - The phase state, counters and done timing are unchanged.
  - The effective MIN_PERIOD clamp becomes max(MIN_PERIOD,4).
- Undefined: no bounce_en port; outputs are clean as specified above.

Decomposition:
- Shared package holds:
  - the FSM state encoding (IDLE/RUN/DONE);
  - quadrature phase constants (PH_00, PH_10, PH_11, PH_01);
  - direction constants DIR_CW=0, DIR_CCW=1.
- One sub-module, quad_channel_gen, instantiated per wheel. It owns the period counter, remaining count, phase register and optional bounce logic. Its ports are load, run, dir, edges, period, A, B, edges_done and finished. The top level holds the FSM and handshake.

Test Plan:
- Reset, then observe idle → A/B all 0, ready=1, busy=0, done=0, edges_done=0.
- start at T with left CW, edges=4, period=3, right edges=0 → left (A,B)=10,11,01,00 at T+3,6,9,12; done=1 only at T+13; right stays 00; edges_done_left=4.
- Right CCW, edges=4, period=5 → right 01,11,10,00 at T+5,10,15,20. Then left edges=8, period=2 with right edges=2, period=10 → left finishes at T+16, right at T+20; done at T+21.
- period_left=0, edges=2 → edges at T+2 and T+4 (clamped to MIN_PERIOD); start pulsed during RUN → ignored, edges_done unchanged.
- abort after the 2nd left edge (CW, period 3) → A/B hold at 11, edges_done_left=2, no done pulse, ready=1 next cycle. A new CW command continues with 01.
- Reset asserted mid-RUN → outputs 00 in the same cycle, without waiting for a clock edge. With ENCODER_BOUNCE_INJECT_EN and bounce_en=1 → A_left shows the 1,0,1 glitch after each rising edge.

Source files
------------

// File: rtl/dual_wheel_encoder_emulator_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dual_wheel_encoder_emulator_pkg
// Purpose  : Shared FSM encoding, quadrature phase and direction constants,
//            and the one-step quadrature phase advance helper.
// Options  : none (ENCODER_BOUNCE_INJECT_EN is consumed by the other files)
// Revision : 1.0 - initial release
// ============================================================================
package dual_wheel_encoder_emulator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Phase constants are {A,B}
  localparam logic [1:0] PH_00 = 2'b00;
  localparam logic [1:0] PH_10 = 2'b10;
  localparam logic [1:0] PH_11 = 2'b11;
  localparam logic [1:0] PH_01 = 2'b01;

  localparam logic DIR_CW  = 1'b0;
  localparam logic DIR_CCW = 1'b1;

  // CW walks 00->10->11->01, CCW walks the same ring backwards
  function automatic logic [1:0] next_phase(input logic [1:0] ph, input logic dir);
    logic [1:0] nxt;
    nxt = PH_00;
    case (ph)
      PH_00:   nxt = (dir == DIR_CW)  ? PH_10 : PH_01;
      PH_10:   nxt = (dir == DIR_CCW) ? PH_00 : PH_11;
      PH_11:   nxt = (dir == DIR_CCW) ? PH_10 : PH_01;
      default: nxt = (dir == DIR_CCW) ? PH_11 : PH_00;
    endcase
    return nxt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dual_wheel_encoder_emulator_quad_channel.sv
`default_nettype none
// ============================================================================
// Module   : quad_channel_gen
// Purpose  : One wheel's quadrature generator: period counter, remaining
//            edge count, persistent phase register and progress counter.
// Options  : ENCODER_BOUNCE_INJECT_EN adds bounce_en, which drops A low for
//            one cycle after each rising A edge; minimum period becomes 4.
// Revision : 1.0 - initial release
// ============================================================================
module quad_channel_gen
  import dual_wheel_encoder_emulator_pkg::*;
#(
  parameter int COUNT_W    = 16,
  parameter int PERIOD_W   = 16,
  parameter int MIN_PERIOD = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic                run,
  input  logic                dir,
  input  logic [COUNT_W-1:0]  edges,
  input  logic [PERIOD_W-1:0] period,
`ifdef ENCODER_BOUNCE_INJECT_EN
  input  logic                bounce_en,
`endif
  output logic                A,
  output logic                B,
  output logic [COUNT_W-1:0]  edges_done,
  output logic                finished
);

`ifdef ENCODER_BOUNCE_INJECT_EN
  // The glitch needs room for high/low/high before the next edge
  localparam int c_eff_min = (MIN_PERIOD > 4) ? MIN_PERIOD : 4;
`else
  localparam int c_eff_min = MIN_PERIOD;
`endif
  localparam logic [PERIOD_W-1:0] c_min_period = PERIOD_W'(c_eff_min);

  logic                r_dir;
  logic [COUNT_W-1:0]  r_remaining;
  logic [COUNT_W-1:0]  r_edges_done;
  logic [PERIOD_W-1:0] r_period;
  logic [PERIOD_W-1:0] r_cnt;
  logic [1:0]          r_phase;

  logic                w_active;
  logic                w_step;
  logic [1:0]          w_phase_nxt;

  assign w_active    = run && (r_remaining != '0);
  assign w_step      = w_active && (r_cnt == r_period - 1'b1);
  assign w_phase_nxt = w_step ? next_phase(r_phase, r_dir) : r_phase;

  // Command latch on load, then period counting and edge bookkeeping while run
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dir        <= DIR_CW;
      r_remaining  <= '0;
      r_edges_done <= '0;
      r_period     <= c_min_period;
      r_cnt        <= '0;
    end else if (load) begin
      r_dir        <= dir;
      r_remaining  <= edges;
      r_edges_done <= '0;
      r_period     <= (period < c_min_period) ? c_min_period : period;
      r_cnt        <= '0;
    end else if (w_active) begin
      if (w_step) begin
        r_cnt        <= '0;
        r_remaining  <= r_remaining - 1'b1;
        r_edges_done <= r_edges_done + 1'b1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Phase survives across commands; only reset returns it to 00
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_phase <= PH_00;
    else       r_phase <= w_phase_nxt;
  end

`ifdef ENCODER_BOUNCE_INJECT_EN
  logic r_a;
  logic r_rise_d;

  // Registered A with a one-cycle low pulse right after a rising step
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a      <= 1'b0;
      r_rise_d <= 1'b0;
    end else begin
      r_rise_d <= bounce_en && w_step && w_phase_nxt[1] && !r_phase[1];
      r_a      <= r_rise_d ? 1'b0 : w_phase_nxt[1];
    end
  end

  assign A = r_a;
`else
  assign A = r_phase[1];
`endif

  assign B          = r_phase[0];
  assign edges_done = r_edges_done;
  assign finished   = (r_remaining == '0);

endmodule
`default_nettype wire

// File: rtl/dual_wheel_encoder_emulator.sv
`default_nettype none
// ============================================================================
// Module   : dual_wheel_encoder_emulator
// Purpose  : Two-wheel quadrature encoder emulator; command handshake FSM
//            (IDLE/RUN/DONE) driving one quad_channel_gen per wheel.
// Options  : ENCODER_BOUNCE_INJECT_EN adds the bounce_en input.
// Revision : 1.0 - initial release
// ============================================================================
module dual_wheel_encoder_emulator
  import dual_wheel_encoder_emulator_pkg::*;
#(
  parameter int COUNT_W    = 16,
  parameter int PERIOD_W   = 16,
  parameter int MIN_PERIOD = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic                dir_left,
  input  logic                dir_right,
  input  logic [COUNT_W-1:0]  edges_left,
  input  logic [COUNT_W-1:0]  edges_right,
  input  logic [PERIOD_W-1:0] period_left,
  input  logic [PERIOD_W-1:0] period_right,
`ifdef ENCODER_BOUNCE_INJECT_EN
  input  logic                bounce_en,
`endif
  output logic                A_left,
  output logic                B_left,
  output logic                A_right,
  output logic                B_right,
  output logic                ready,
  output logic                busy,
  output logic                done,
  output logic [COUNT_W-1:0]  edges_done_left,
  output logic [COUNT_W-1:0]  edges_done_right
);

  state_t r_state;
  logic   r_ready;
  logic   r_busy;
  logic   r_done;

  logic   w_load;
  logic   w_run;
  logic   w_fin_left;
  logic   w_fin_right;

  // Abort gates the channels on its own edge so the phase holds where it is
  assign w_load = (r_state == ST_IDLE) && start && !abort;
  assign w_run  = (r_state == ST_RUN) && !abort;

  // Handshake FSM with registered ready/busy/done flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_load) begin
            r_state <= ST_RUN;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        ST_RUN: begin
          if (abort) begin
            r_state <= ST_IDLE;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
          end else if (w_fin_left && w_fin_right) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  quad_channel_gen #(
    .COUNT_W    (COUNT_W),
    .PERIOD_W   (PERIOD_W),
    .MIN_PERIOD (MIN_PERIOD)
  ) u_left (
    .clk        (clk),
    .reset      (reset),
    .load       (w_load),
    .run        (w_run),
    .dir        (dir_left),
    .edges      (edges_left),
    .period     (period_left),
`ifdef ENCODER_BOUNCE_INJECT_EN
    .bounce_en  (bounce_en),
`endif
    .A          (A_left),
    .B          (B_left),
    .edges_done (edges_done_left),
    .finished   (w_fin_left)
  );

  quad_channel_gen #(
    .COUNT_W    (COUNT_W),
    .PERIOD_W   (PERIOD_W),
    .MIN_PERIOD (MIN_PERIOD)
  ) u_right (
    .clk        (clk),
    .reset      (reset),
    .load       (w_load),
    .run        (w_run),
    .dir        (dir_right),
    .edges      (edges_right),
    .period     (period_right),
`ifdef ENCODER_BOUNCE_INJECT_EN
    .bounce_en  (bounce_en),
`endif
    .A          (A_right),
    .B          (B_right),
    .edges_done (edges_done_right),
    .finished   (w_fin_right)
  );

  assign ready = r_ready;
  assign busy  = r_busy;
  assign done  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_dual_wheel_encoder_emulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_dual_wheel_encoder_emulator
// Purpose  : Self-checking bench for dual_wheel_encoder_emulator.
// Options  : ENCODER_BOUNCE_INJECT_EN connects bounce_en and runs the
//            glitch sequence.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dual_wheel_encoder_emulator;

`ifdef ENCODER_BOUNCE_INJECT_EN
  localparam int MINP = 4;
`else
  localparam int MINP = 2;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        dir_left = 1'b0;
  logic        dir_right = 1'b0;
  logic [15:0] edges_left = '0;
  logic [15:0] edges_right = '0;
  logic [15:0] period_left = '0;
  logic [15:0] period_right = '0;
  logic        bnc = 1'b0;
  logic        A_left, B_left, A_right, B_right;
  logic        ready, busy, done;
  logic [15:0] edges_done_left, edges_done_right;

  typedef struct {
    logic       dl;
    logic       dr;
    int         el;
    int         er;
    int         pl;
    int         pr;
    logic [1:0] fin_l;
    logic [1:0] fin_r;
  } cmd_t;

  typedef struct {
    int         cyc;
    logic [1:0] abl;
    logic [1:0] abr;
    logic       rdy;
    logic       bsy;
    logic       dn;
    int         edl;
    int         edr;
  } exp_t;

  exp_t       q[$];
  exp_t       m_e;
  int         cyc = 0;
  int         errors = 0;
  int         checks = 0;
  logic [1:0] ph_l = 2'b00;
  logic [1:0] ph_r = 2'b00;

  dual_wheel_encoder_emulator #(
    .COUNT_W    (16),
    .PERIOD_W   (16),
    .MIN_PERIOD (2)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .abort            (abort),
    .dir_left         (dir_left),
    .dir_right        (dir_right),
    .edges_left       (edges_left),
    .edges_right      (edges_right),
    .period_left      (period_left),
    .period_right     (period_right),
`ifdef ENCODER_BOUNCE_INJECT_EN
    .bounce_en        (bnc),
`endif
    .A_left           (A_left),
    .B_left           (B_left),
    .A_right          (A_right),
    .B_right          (B_right),
    .ready            (ready),
    .busy             (busy),
    .done             (done),
    .edges_done_left  (edges_done_left),
    .edges_done_right (edges_done_right)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference quadrature ring in CW order {A,B}: 00,10,11,01
  function automatic logic [1:0] walk(input logic [1:0] ph, input logic d, input int n);
    logic [1:0] ring [4];
    int idx;
    ring = '{2'b00, 2'b10, 2'b11, 2'b01};
    idx = 0;
    for (int i = 0; i < 4; i++) if (ring[i] == ph) idx = i;
    idx = d ? (idx + 4 - (n % 4)) % 4 : (idx + n) % 4;
    return ring[idx];
  endfunction

  function automatic int clampp(input int p);
    return (p < MINP) ? MINP : p;
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int done_k(input cmd_t c);
    int a, b;
    a = c.el * clampp(c.pl);
    b = c.er * clampp(c.pr);
    return ((a > b) ? a : b) + 1;
  endfunction

  // Expected visible state k cycles after the accepting edge
  function automatic exp_t model(input cmd_t c, input logic [1:0] l0, input logic [1:0] r0,
                                 input int k, input int abortk, input logic bo);
    exp_t e;
    int pl, pr, kk, nl, nr, kd;
    bit ab;
    logic [1:0] prev;
    pl = clampp(c.pl);
    pr = clampp(c.pr);
    ab = (abortk > 0) && (k >= abortk);
    kk = ab ? abortk - 1 : k;
    nl = imin(c.el, kk / pl);
    nr = imin(c.er, kk / pr);
    e.abl = walk(l0, c.dl, nl);
    e.abr = walk(r0, c.dr, nr);
    if (bo && !ab) begin
      if (((k - 1) % pl == 0) && ((k - 1) / pl >= 1) && ((k - 1) / pl <= c.el)) begin
        prev = walk(l0, c.dl, nl - 1);
        if (e.abl[1] && !prev[1]) e.abl[1] = 1'b0;
      end
      if (((k - 1) % pr == 0) && ((k - 1) / pr >= 1) && ((k - 1) / pr <= c.er)) begin
        prev = walk(r0, c.dr, nr - 1);
        if (e.abr[1] && !prev[1]) e.abr[1] = 1'b0;
      end
    end
    e.edl = nl;
    e.edr = nr;
    kd = done_k(c);
    if (abortk > 0) begin
      e.bsy = !ab;
      e.rdy = ab;
      e.dn  = 1'b0;
    end else begin
      e.bsy = (k < kd);
      e.dn  = (k == kd);
      e.rdy = (k > kd);
    end
    e.cyc = 0;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Drive a command for one cycle and queue the expected per-cycle snapshots
  task automatic launch(input cmd_t c, input int abortk, input int kpush);
    int t, kend, nl, nr;
    exp_t e;
    @(negedge clk);
    dir_left     = c.dl;
    dir_right    = c.dr;
    edges_left   = 16'(c.el);
    edges_right  = 16'(c.er);
    period_left  = 16'(c.pl);
    period_right = 16'(c.pr);
    start        = 1'b1;
    t = cyc + 1;
    kend = (abortk > 0) ? abortk + 2 : done_k(c) + 1;
    if (kpush > 0) kend = kpush;
    for (int k = 1; k <= kend; k++) begin
      e = model(c, ph_l, ph_r, k, abortk, bnc);
      e.cyc = t + k;
      q.push_back(e);
    end
    nl = (abortk > 0) ? imin(c.el, (abortk - 1) / clampp(c.pl)) : c.el;
    nr = (abortk > 0) ? imin(c.er, (abortk - 1) / clampp(c.pr)) : c.er;
    ph_l = walk(ph_l, c.dl, nl);
    ph_r = walk(ph_r, c.dr, nr);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 3000 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expected snapshots never reached", q.size());
      q.delete();
    end
  endtask

  // Scoreboard monitor: compare the head snapshot on its cycle
  always @(negedge clk) begin
    if (q.size() > 0 && q[0].cyc <= cyc) begin
      m_e = q.pop_front();
      checks++;
      if (m_e.cyc != cyc ||
          {A_left, B_left} !== m_e.abl || {A_right, B_right} !== m_e.abr ||
          ready !== m_e.rdy || busy !== m_e.bsy || done !== m_e.dn ||
          edges_done_left !== 16'(m_e.edl) || edges_done_right !== 16'(m_e.edr)) begin
        errors++;
        $display("FAIL snap cyc=%0d(want %0d): ABl=%b ABr=%b rdy=%b bsy=%b dn=%b edl=%0d edr=%0d required ABl=%b ABr=%b rdy=%b bsy=%b dn=%b edl=%0d edr=%0d",
                 cyc, m_e.cyc, {A_left, B_left}, {A_right, B_right}, ready, busy, done,
                 edges_done_left, edges_done_right, m_e.abl, m_e.abr, m_e.rdy, m_e.bsy,
                 m_e.dn, m_e.edl, m_e.edr);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cmd_t tbl [4];
    cmd_t c;

    tbl[0] = '{1'b0, 1'b0, 4, 0, 3, 1, 2'b00, 2'b00};
    tbl[1] = '{1'b0, 1'b1, 0, 4, 1, 5, 2'b00, 2'b00};
    tbl[2] = '{1'b0, 1'b0, 8, 2, 2, 10, 2'b00, 2'b11};
    tbl[3] = '{1'b0, 1'b0, 0, 0, 3, 3, 2'b00, 2'b11};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ab", {28'd0, A_left, B_left, A_right, B_right}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_ab", {28'd0, A_left, B_left, A_right, B_right}, 32'd0);
    chk("idle_ready", {31'd0, ready}, 32'd1);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_done", {31'd0, done}, 32'd0);
    chk("idle_edl", {16'd0, edges_done_left}, 32'd0);
    chk("idle_edr", {16'd0, edges_done_right}, 32'd0);

    // start together with abort in IDLE is ignored
    start = 1'b1;
    abort = 1'b1;
    edges_left = 16'd3;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_ready", {31'd0, ready}, 32'd1);
    chk("start_abort_busy", {31'd0, busy}, 32'd0);

    // Table-driven commands
    for (int i = 0; i < 4; i++) begin
      launch(tbl[i], 0, 0);
      drain();
      chk($sformatf("tbl%0d_fin_l", i), {30'd0, A_left, B_left}, {30'd0, tbl[i].fin_l});
      chk($sformatf("tbl%0d_fin_r", i), {30'd0, A_right, B_right}, {30'd0, tbl[i].fin_r});
    end

    // Abort after the second left edge, then resume in the same direction
    c = '{1'b0, 1'b0, 8, 0, 3, 1, 2'b00, 2'b00};
    launch(c, 2 * clampp(3) + 1, 0);
    repeat (2 * clampp(3)) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    drain();
    chk("abort_ab_l", {30'd0, A_left, B_left}, 32'b11);
    chk("abort_edl", {16'd0, edges_done_left}, 32'd2);
    c = '{1'b0, 1'b0, 1, 0, 3, 1, 2'b00, 2'b00};
    launch(c, 0, 0);
    drain();
    chk("resume_ab_l", {30'd0, A_left, B_left}, 32'b01);

    // Period below the clamp, with a stray start during RUN
    c = '{1'b0, 1'b0, 2, 0, 0, 0, 2'b00, 2'b00};
    launch(c, 0, 0);
    start = 1'b1;
    dir_left = 1'b1;
    edges_left = 16'd9;
    @(negedge clk);
    start = 1'b0;
    drain();
    chk("clamp_edl", {16'd0, edges_done_left}, 32'd2);

    // Asynchronous reset in the middle of a run
    c = '{1'b0, 1'b0, 8, 0, 3, 1, 2'b00, 2'b00};
    launch(c, 0, 7);
    drain();
    chk("pre_rst_ab_r", {30'd0, A_right, B_right}, 32'b11);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_ab", {28'd0, A_left, B_left, A_right, B_right}, 32'd0);
    chk("async_rst_edl", {16'd0, edges_done_left}, 32'd0);
    chk("async_rst_ready", {31'd0, ready}, 32'd1);
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    ph_l = 2'b00;
    ph_r = 2'b00;

`ifdef ENCODER_BOUNCE_INJECT_EN
    bnc = 1'b1;
    c = '{1'b0, 1'b1, 4, 2, 4, 4, 2'b00, 2'b00};
    launch(c, 0, 0);
    drain();
    bnc = 1'b0;
`endif

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
